// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain feeder: serialises bitstream words MSB-first onto ccff_head,
// gates prog_clk per shifted bit, and holds IO isolation until the chain has settled.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN  = 64,
  parameter int WORD_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_N,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              tail_parity,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int LEFT_W = $clog2(WORD_W + 1);
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0]  C_LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [LEFT_W-1:0] C_WORD     = LEFT_W'(WORD_W);
  localparam logic [SET_W-1:0]  C_SET_LAST = SET_W'(SETTLE_CYC - 1);

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [LEFT_W-1:0] r_left;
  logic [SET_W-1:0]  r_settle_cnt;

  logic [1:0]        w_nxt_state;
  logic [WORD_W-1:0] w_nxt_shreg;
  logic [LEFT_W-1:0] w_nxt_left;
  logic [CNT_W-1:0]  w_nxt_count;
  logic [SET_W-1:0]  w_nxt_settle;
  logic              w_room;
  logic              w_shift;
  logic              w_clr_parity;

  assign w_room = (bit_count < C_LEN);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_shreg  = r_shreg;
    w_nxt_left   = r_left;
    w_nxt_count  = bit_count;
    w_nxt_settle = r_settle_cnt;
    w_shift      = 1'b0;
    w_clr_parity = 1'b0;
    if (abort) begin
      w_nxt_state = S_IDLE;
      w_nxt_shreg = '0;
      w_nxt_left  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_nxt_state  = S_LOAD;
            w_nxt_count  = '0;
            w_nxt_shreg  = '0;
            w_nxt_left   = '0;
            w_clr_parity = 1'b1;
          end
        end
        S_LOAD: begin
          // Reaching the chain length drops any unshifted bits of a partial last word.
          if (!w_room) begin
            w_nxt_state  = S_SETTLE;
            w_nxt_left   = '0;
            w_nxt_settle = '0;
          end else if (r_left == '0) begin
            if (word_ready && word_valid) begin
              w_nxt_shreg = word_data;
              w_nxt_left  = C_WORD;
            end
          end else begin
            w_shift     = 1'b1;
            w_nxt_shreg = r_shreg << 1;
            w_nxt_left  = r_left - LEFT_W'(1);
            w_nxt_count = bit_count + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == C_SET_LAST) w_nxt_state = S_DONE;
          else                            w_nxt_settle = r_settle_cnt + SET_W'(1);
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge prog_clk or negedge pReset_N) begin
    if (!pReset_N) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_left        <= '0;
      r_settle_cnt  <= '0;
      bit_count     <= '0;
      word_ready    <= 1'b0;
      ccff_head     <= 1'b0;
      prog_clk_en   <= 1'b0;
      config_enable <= 1'b0;
      IO_ISOL_N     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tail_parity   <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_shreg       <= w_nxt_shreg;
      r_left        <= w_nxt_left;
      r_settle_cnt  <= w_nxt_settle;
      bit_count     <= w_nxt_count;
      word_ready    <= (w_nxt_state == S_LOAD) && (w_nxt_left == '0) && (w_nxt_count < C_LEN);
      prog_clk_en   <= w_shift;
      if (w_shift) ccff_head <= r_shreg[WORD_W-1];
      config_enable <= (w_nxt_state == S_LOAD);
      busy          <= (w_nxt_state == S_LOAD) || (w_nxt_state == S_SETTLE);
      done          <= (w_nxt_state == S_DONE);
      IO_ISOL_N     <= (w_nxt_state == S_DONE);
      if (w_clr_parity)              tail_parity <= 1'b0;
      else if (prog_clk_en && !abort) tail_parity <= tail_parity ^ ccff_tail;
    end
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain feeder that sits directly upstream of the grid tiles' `ccff_head` inputs.
- Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto `ccff_head`, one bit per enabled `prog_clk` cycle.
- Drives `config_enable` and the per-bit clock-gate enable while loading.
- Holds IO isolation until the chain is fully loaded and settled.
- Reports the XOR parity of the bits shifted out of `ccff_tail`, giving a readback signature of the chain's previous contents.

Parameters:
- CHAIN_LEN, 64, total configuration bits in the chain (>=1).
- WORD_W, 8, bitstream word width.
- SETTLE_CYC, 4, cycles with `config_enable` low after the last shift and before `done` (>=1).
- CNT_W, 16, width of the bit counter; must hold CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock, rising edge.
- pReset_N  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE.
- abort  input  1  one-cycle pulse; cancels any operation.
- word_data  input  WORD_W  bitstream word, MSB shifted first.
- word_valid  input  1  `word_data` valid.
- word_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial config bit to the chain head.
- prog_clk_en  output  1  clock-gate enable; chain shifts on edges where it is 1.
- ccff_tail  input  1  serial output of the chain tail.
- config_enable  output  1  chain programming enable.
- IO_ISOL_N  output  1  active-low IO isolation; 0 = isolated.
- busy  output  1  LOAD or SETTLE.
- done  output  1  load completed; held until the next start or abort.
- tail_parity  output  1  XOR of `ccff_tail` over all shift cycles of the current load.
- bit_count  output  CNT_W  bits shifted so far.

Behaviour:
- Interface: one clock (`prog_clk`); reset is asynchronous and active-low (`pReset_N`). All outputs are registered.
- Reset: state = IDLE. All outputs 0, including `IO_ISOL_N` (isolated) and `bit_count`.
- States: IDLE, LOAD, SETTLE, DONE.
- IDLE/DONE + `start`:
  - go to LOAD next cycle;
  - `bit_count` <= 0, `tail_parity` <= 0, `done` <= 0;
  - `config_enable` <= 1, `IO_ISOL_N` <= 0.
- LOAD, word acceptance:
  - Internal shift register `shreg` (WORD_W bits) with `left` = bits remaining in it.
  - `word_ready` = 1 when in LOAD, `left` == 0, and `bit_count` < CHAIN_LEN.
  - Handshake `word_valid & word_ready` loads `shreg` <= `word_data`, `left` <= WORD_W.
  - No shift occurs in the acceptance cycle.
- LOAD, shifting (each cycle with `left` > 0 and `bit_count` < CHAIN_LEN):
  - `ccff_head` <= `shreg[MSB]`, `prog_clk_en` <= 1;
  - `shreg` shifts left with 0 fill, `left`--, `bit_count`++.
  - Otherwise `prog_clk_en` <= 0 and `ccff_head` holds its value. Underrun stalls with no error.
- `tail_parity` ^= `ccff_tail` on every cycle where the `prog_clk_en` output is 1.
- Partial last word: when CHAIN_LEN is not a multiple of WORD_W, only its top (CHAIN_LEN mod WORD_W) bits are shifted. The remaining bits are discarded and no further words are accepted.
- Entering SETTLE: when `bit_count` reaches CHAIN_LEN, the next cycle enters SETTLE with `config_enable` <= 0 and `prog_clk_en` <= 0.
- SETTLE: lasts exactly SETTLE_CYC cycles, then enters DONE.
- DONE: `done` = 1, `IO_ISOL_N` = 1, `busy` = 0. Outputs hold until `start` or `abort`.
- `start` during LOAD or SETTLE: ignored.
- `abort` (any state):
  - next state IDLE;
  - `config_enable`, `prog_clk_en`, `busy`, `done` <= 0;
  - `IO_ISOL_N` <= 0 (stays isolated);
  - `shreg` and `left` cleared; `bit_count` and `tail_parity` hold.
- `abort` and `start` in the same cycle: `abort` wins.
- Reset mid-LOAD: immediate return to reset values. The partially loaded chain is treated as invalid.

Test Plan:
- Basic load: CHAIN_LEN=16, WORD_W=8, words 0xA5 and 0x3C always valid -> `ccff_head` sequence 1010010100111100 over 16 `prog_clk_en` cycles; `config_enable` drops; `done`=1 and `IO_ISOL_N`=1 after 4 SETTLE cycles; `bit_count`=16.
- Partial word: CHAIN_LEN=20, words 0xFF, 0x00, 0xF0 -> 20 shifts, last four bits 1111; `word_ready` never reasserts after the third word; low nibble discarded.
- Underrun: `word_valid` deasserted for 5 cycles between words -> `prog_clk_en`=0 for those cycles, `ccff_head` stable, final bit sequence unchanged.
- Tail parity: `ccff_tail` driven 1 on exactly 3 of the 16 shift cycles -> `tail_parity`=1; driven 1 on exactly 2 -> 0.
- Abort after bit 9: `config_enable`=0, `IO_ISOL_N`=0, `done`=0, `bit_count`=9 held; a following `start` restarts from `bit_count`=0.
- Async reset asserted mid-SETTLE: all outputs 0 immediately without a clock edge; `start` after release runs a full load.
